// File: rtl/cdcl_level_ctrl_pkg.sv
// cdcl_level_ctrl_pkg: shared state type and level-width helper for the CDCL level controller
package cdcl_level_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROP,
        S_DECIDE,
        S_ANALYZE,
        S_BACKTRACK,
        S_DONE
    } state_e;

    function automatic int lw_f(input int literals);
        return $clog2(literals + 1);
    endfunction

endpackage

// File: rtl/cdcl_level_ctrl_counter.sv
// counter: saturating up/down counter holding values 0..literals-1
module counter #(
    parameter int literals = 9,
    localparam int W = $clog2(literals)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_i,
    input  logic         incr_i,
    output logic [W-1:0] count_o
);

    // count moves one step per enabled cycle and never wraps at either end
    always_ff @(posedge clk) begin
        if (!rst)
            count_o <= '0;
        else if (enable_i && incr_i && count_o != W'(literals - 1))
            count_o <= count_o + 1'b1;
        else if (enable_i && !incr_i && count_o != '0)
            count_o <= count_o - 1'b1;
    end

endmodule

// File: rtl/cdcl_level_ctrl.sv
// cdcl_level_ctrl: CDCL decision-level sequencer driving propagate/decide/analyze/backtrack
module cdcl_level_ctrl
    import cdcl_level_ctrl_pkg::*;
#(
    parameter int LITERALS = 8,
    localparam int LW = lw_f(LITERALS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          prop_start,
    input  logic          prop_done,
    input  logic          prop_conflict,
    output logic          decide_req,
    input  logic          decide_ack,
    input  logic          decide_none,
    output logic          ana_start,
    input  logic          ana_done,
    input  logic [LW-1:0] ana_level,
    output logic          bt_step,
    output logic [LW-1:0] level,
    output logic          done,
    output logic          sat
);

    state_e        state_q, state_d;
    logic [LW-1:0] target_q, target_d, level_d;
    logic          done_q, done_d, sat_q, sat_d;
    logic          prop_start_q, prop_start_d, ana_start_q, ana_start_d;
    logic          decide_req_q, decide_req_d, bt_step_q, bt_step_d;
    logic          cnt_en, cnt_inc;

    counter #(.literals(LITERALS + 1)) u_level (
        .clk      (clk),
        .rst      (rst),
        .enable_i (cnt_en),
        .incr_i   (cnt_inc),
        .count_o  (level)
    );

    // next state, counter control, and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        done_d   = done_q;
        sat_d    = sat_q;
        cnt_en   = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            S_IDLE: state_d = start ? S_PROP : S_IDLE;
            S_PROP: begin
                if (prop_done) begin
                    state_d = !prop_conflict ? S_DECIDE : (level == '0) ? S_DONE : S_ANALYZE;
                    done_d  = prop_conflict && level == '0;
                    sat_d   = 1'b0;
                end
            end
            S_DECIDE: begin
                if (level == LW'(LITERALS) || decide_none) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    sat_d   = 1'b1;
                end else if (decide_ack) begin
                    state_d = S_PROP;
                    cnt_en  = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            S_ANALYZE: begin
                if (ana_done) begin
                    state_d  = S_BACKTRACK;
                    target_d = (ana_level >= level) ? level - 1'b1 : ana_level;
                end
            end
            S_BACKTRACK: begin
                cnt_en  = level > target_q;
                state_d = (level > target_q && (level - 1'b1) != target_q) ? S_BACKTRACK : S_PROP;
            end
            S_DONE: begin
                if (start) begin
                    state_d  = S_BACKTRACK;
                    target_d = '0;
                    done_d   = 1'b0;
                    sat_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        level_d      = cnt_en ? (cnt_inc ? level + 1'b1 : level - 1'b1) : level;
        prop_start_d = state_d == S_PROP && state_q != S_PROP;
        ana_start_d  = state_d == S_ANALYZE && state_q != S_ANALYZE;
        decide_req_d = state_d == S_DECIDE && level_d != LW'(LITERALS);
        bt_step_d    = state_d == S_BACKTRACK && level_d > target_d;
    end

    // state, backjump target and all outputs are registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            prop_start_q <= 1'b0;
            ana_start_q  <= 1'b0;
            decide_req_q <= 1'b0;
            bt_step_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            done_q       <= done_d;
            sat_q        <= sat_d;
            prop_start_q <= prop_start_d;
            ana_start_q  <= ana_start_d;
            decide_req_q <= decide_req_d;
            bt_step_q    <= bt_step_d;
        end
    end

    assign prop_start = prop_start_q;
    assign ana_start  = ana_start_q;
    assign decide_req = decide_req_q;
    assign bt_step    = bt_step_q;
    assign done       = done_q;
    assign sat        = sat_q;

endmodule
